// File: rtl/jtframe_dump_trigger.sv
// Dump-window trigger: counts frames from vertical sync and opens a capture window
// either at a chosen frame number or on the falling edge of the download LED.
module jtframe_dump_trigger #(
  parameter int CNTW    = 32,
  parameter bit VS_NEG  = 1'b1,
  parameter int HOLDOFF = 20000,
  parameter int HOLDW   = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vs,
  input  logic            led,
  input  logic            arm,
  input  logic            mode,
  input  logic [CNTW-1:0] start_frame,
  input  logic [15:0]     dump_len,
  output logic [CNTW-1:0] frame_cnt,
  output logic            frame_tick,
  output logic            dump_en,
  output logic            dump_start,
  output logic            dump_stop,
  output logic [1:0]      st
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [15:0]     frames_left, left_next;
  logic            vs_s1, vs_s2, vs_d;
  logic            led_s1, led_s2, led_d;
  logic [HOLDW-1:0] hold_cnt;
  logic            hold_done;
  logic            vs_edge, led_fall;
  logic [CNTW-1:0] cnt_next;
  logic            start_next, stop_next;

  // Two-stage synchronisers followed by one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1  <= 1'b0;
      vs_s2  <= 1'b0;
      vs_d   <= 1'b0;
      led_s1 <= 1'b0;
      led_s2 <= 1'b0;
      led_d  <= 1'b0;
    end else begin
      vs_s1  <= vs;
      vs_s2  <= vs_s1;
      vs_d   <= vs_s2;
      led_s1 <= led;
      led_s2 <= led_s1;
      led_d  <= led_s2;
    end
  end

  assign vs_edge   = VS_NEG ? (vs_d & ~vs_s2) : (~vs_d & vs_s2);
  assign led_fall  = led_d & ~led_s2;
  assign hold_done = (hold_cnt == HOLDW'(HOLDOFF));
  assign cnt_next  = frame_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (!hold_done) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_tick <= vs_edge;
      if (vs_edge) frame_cnt <= cnt_next;
    end
  end

  // State register; start/stop pulses are registered so they line up with frame_tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      frames_left <= '0;
      dump_start  <= 1'b0;
      dump_stop   <= 1'b0;
    end else begin
      state       <= state_next;
      frames_left <= left_next;
      dump_start  <= start_next;
      dump_stop   <= stop_next;
    end
  end

  // frames_left == 0 while in DUMP means an open-ended window
  always_comb begin
    state_next = state;
    left_next  = frames_left;
    if (!arm) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_next = S_WAIT;
        S_WAIT: begin
          if (mode ? (led_fall && hold_done) : (vs_edge && cnt_next == start_frame)) begin
            state_next = S_DUMP;
            left_next  = dump_len;
          end
        end
        S_DUMP: begin
          if (vs_edge && frames_left != 16'd0) begin
            left_next = frames_left - 16'd1;
            if (frames_left == 16'd1) state_next = S_DONE;
          end
        end
        S_DONE: state_next = S_DONE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    start_next = (state != S_DUMP) && (state_next == S_DUMP);
    stop_next  = (state == S_DUMP) && (state_next != S_DUMP);
    dump_en    = (state == S_DUMP);
    st         = state;
  end

endmodule

// File: tb/tb_jtframe_dump_trigger.sv
// Directed bench for jtframe_dump_trigger: a frame-by-frame vector table plus
// hand-written sequences for the LED trigger, disarm race, wrap and reset cases.
module tb_jtframe_dump_trigger;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b0;
  logic        led = 1'b0;
  logic        arm = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  start_frame = '0;
  logic [15:0] dump_len = '0;
  logic [3:0]  frame_cnt;
  logic        frame_tick, dump_en, dump_start, dump_stop;
  logic [1:0]  st;

  int checks = 0;
  int errors = 0;

  jtframe_dump_trigger #(
    .CNTW    (4),
    .VS_NEG  (1'b1),
    .HOLDOFF (1000),
    .HOLDW   (11)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vs          (vs),
    .led         (led),
    .arm         (arm),
    .mode        (mode),
    .start_frame (start_frame),
    .dump_len    (dump_len),
    .frame_cnt   (frame_cnt),
    .frame_tick  (frame_tick),
    .dump_en     (dump_en),
    .dump_start  (dump_start),
    .dump_stop   (dump_stop),
    .st          (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        arm;
    logic [3:0]  sf;
    logic [15:0] len;
    logic [3:0]  cnt;
    logic        en;
    logic        start;
    logic        stop;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    arm = 1'b0; mode = 1'b0; vs = 1'b0; led = 1'b0;
    #1;
    check("rst frame_cnt", 32'(frame_cnt), 0);
    check("rst outputs", {28'd0, frame_tick, dump_en, dump_start, dump_stop}, 0);
    check("rst st", 32'(st), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One vs pulse; returns with the bench sitting on the negedge that shows frame_tick
  task automatic frame();
    bit ok;
    vs = 1'b1;
    repeat (4) @(negedge clk);
    vs = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_tick timeout: got no pulse in 8 cycles, required one");
    end
  endtask

  initial begin
    //            arm sf  len  cnt en st sp st
    vecs[0] = '{1'b0, 4'd5, 16'd3, 4'd1,  1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1] = '{1'b0, 4'd5, 16'd3, 4'd2,  1'b0, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{1'b1, 4'd5, 16'd3, 4'd3,  1'b0, 1'b0, 1'b0, 2'd1};
    vecs[3] = '{1'b1, 4'd5, 16'd3, 4'd4,  1'b0, 1'b0, 1'b0, 2'd1};
    vecs[4] = '{1'b1, 4'd5, 16'd3, 4'd5,  1'b1, 1'b1, 1'b0, 2'd2};
    vecs[5] = '{1'b1, 4'd5, 16'd0, 4'd6,  1'b1, 1'b0, 1'b0, 2'd2};
    vecs[6] = '{1'b1, 4'd5, 16'd0, 4'd7,  1'b1, 1'b0, 1'b0, 2'd2};
    vecs[7] = '{1'b1, 4'd5, 16'd0, 4'd8,  1'b0, 1'b0, 1'b1, 2'd3};
    vecs[8] = '{1'b1, 4'd9, 16'd3, 4'd9,  1'b0, 1'b0, 1'b0, 2'd3};
    vecs[9] = '{1'b0, 4'd9, 16'd3, 4'd10, 1'b0, 1'b0, 1'b0, 2'd0};

    // Frame counting while disarmed, then a mode-0 window of three frames
    do_reset();
    for (int i = 0; i < 10; i++) begin
      arm = vecs[i].arm;
      start_frame = vecs[i].sf;
      dump_len = vecs[i].len;
      frame();
      check($sformatf("v%0d frame_cnt", i), 32'(frame_cnt), 32'(vecs[i].cnt));
      check($sformatf("v%0d dump_en", i), 32'(dump_en), 32'(vecs[i].en));
      check($sformatf("v%0d dump_start", i), 32'(dump_start), 32'(vecs[i].start));
      check($sformatf("v%0d dump_stop", i), 32'(dump_stop), 32'(vecs[i].stop));
      check($sformatf("v%0d st", i), 32'(st), 32'(vecs[i].st));
    end

    // Mode 1: early led fall is inside hold-off, later one opens an open-ended window
    do_reset();
    mode = 1'b1; dump_len = 16'd0; arm = 1'b1;
    repeat (88) @(negedge clk);
    led = 1'b1;
    repeat (10) @(negedge clk);
    led = 1'b0;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (dump_start) seen = 1'b1;
      end
      check("holdoff ignores led", 32'(seen), 0);
    end
    check("holdoff st", 32'(st), 1);
    repeat (1390) @(negedge clk);
    led = 1'b1;
    repeat (10) @(negedge clk);
    led = 1'b0;
    repeat (2) @(negedge clk);
    check("led start early", 32'(dump_start), 0);
    @(negedge clk);
    check("led start", 32'(dump_start), 1);
    check("led en", 32'(dump_en), 1);
    check("led st", 32'(st), 2);
    for (int i = 0; i < 3; i++) begin
      frame();
      check("len0 en", 32'(dump_en), 1);
      check("len0 stop", 32'(dump_stop), 0);
    end
    arm = 1'b0;
    @(negedge clk);
    check("disarm stop", 32'(dump_stop), 1);
    check("disarm en", 32'(dump_en), 0);
    check("disarm st", 32'(st), 0);
    @(negedge clk);
    check("disarm stop pulse", 32'(dump_stop), 0);

    // Disarm on the very cycle the matching tick arrives
    do_reset();
    start_frame = 4'd3; dump_len = 16'd2; arm = 1'b1;
    frame();
    frame();
    vs = 1'b1;
    repeat (4) @(negedge clk);
    vs = 1'b0;
    repeat (2) @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    check("race tick", 32'(frame_tick), 1);
    check("race cnt", 32'(frame_cnt), 3);
    check("race start", 32'(dump_start), 0);
    check("race st", 32'(st), 0);

    // Start frame already passed: wait for 15 -> 0 wrap
    do_reset();
    start_frame = 4'd2; dump_len = 16'd1;
    repeat (9) frame();
    check("wrap pre cnt", 32'(frame_cnt), 9);
    arm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      frame();
      check("wrap cnt", 32'(frame_cnt), 32'((10 + i) % 16));
      check("wrap no start", 32'(dump_start), 0);
      check("wrap st", 32'(st), 1);
    end
    frame();
    check("wrap match cnt", 32'(frame_cnt), 2);
    check("wrap start", 32'(dump_start), 1);
    frame();
    check("wrap stop", 32'(dump_stop), 1);
    check("wrap done st", 32'(st), 3);

    // Reset in the middle of an open window
    do_reset();
    start_frame = 4'd1; dump_len = 16'd0; arm = 1'b1;
    frame();
    check("pre-rst en", 32'(dump_en), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    arm = 1'b0;
    #1;
    check("async rst en", 32'(dump_en), 0);
    check("async rst pulses", {30'd0, dump_start, dump_stop}, 0);
    check("async rst st", 32'(st), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst st", 32'(st), 0);
    check("post-rst cnt", 32'(frame_cnt), 0);
    check("post-rst stop", 32'(dump_stop), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
